// File: rtl/mem_access_unit.sv
// Load/store responder: one access at a time over an ack-handshaked, byte-enabled word bus; busy stalls the core.
// Minimum latency accept->resp_valid is one cycle after ack; optional misalignment fault via `ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int AW             = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [2:0]    mem_select,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          req_ready,
    output logic          busy,
    output logic          resp_valid,
    output logic [31:0]   rdata_out,
    output logic          bus_error,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_size;
    logic          r_signed;
    logic          r_write;
    logic [1:0]    r_lane;

    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_fault;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    // Lane steering and fault detection on the raw request inputs.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata;
        w_fault = 1'b0;
        case (mem_select[1:0])
            2'd0: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'd1: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
`ifdef ALIGN_CHECK_EN
                w_fault = addr[0];
`endif
            end
            2'd2: begin
                w_be    = 4'b1111;
`ifdef ALIGN_CHECK_EN
                w_fault = |addr[1:0];
`endif
            end
            default: w_fault = 1'b1;
        endcase
    end

    // Load alignment uses the lane/size captured at acceptance, not live inputs.
    always_comb begin
        w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'd0:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
        if (r_write) begin
            w_load = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_size     <= 2'd0;
            r_signed   <= 1'b0;
            r_write    <= 1'b0;
            r_lane     <= 2'd0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            rdata_out  <= 32'd0;
            bus_error  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        rdata_out <= 32'd0;
                        if (w_fault) begin
                            resp_valid <= 1'b1;
                            bus_error  <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {addr[AW-1:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                            r_cnt     <= '0;
                            r_write   <= req_write;
                            r_size    <= mem_select[1:0];
                            r_signed  <= mem_select[2];
                            r_lane    <= addr[1:0];
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // An ack on the same edge as the final timeout count takes priority.
                    if (mem_ack) begin
                        rdata_out  <= w_load;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (r_cnt == TO_LAST) begin
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            resp_valid <= 1'b1;
                            bus_error  <= 1'b1;
                            rdata_out  <= 32'd0;
                            r_state    <= S_RESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
